frame_move_scheduler: RTL and testbench
=======================================

// Module: frame_move_scheduler
// PURPOSE
// Queues 3-bit move commands from two requesters (player input, demo/auto
// pattern) and hands the object-location block exactly one command per video
// frame. Commands are applied at the vsync falling edge, so the object moves
// only between frames and never tears mid-scan. Sits between the command
// sources and the object-location block, in the 25 MHz pixel-clock domain.
// PARAMETERS
// CMD_W    3   command width in bits
// DEPTH    4   FIFO entries; power of 2, >=2
// NOP_CMD  0   "no move" encoding
// PORTS
// clk         in   1      pixel clock (25 MHz)
// reset       in   1      asynchronous, active-high
// vsync       in   1      active-low vsync from the XY counter, same clock
// req0_valid  in   1      requester 0 (player) has a command
// req0_cmd    in   CMD_W  requester 0 command
// req0_ready  out  1      requester 0 command accepted this cycle
// req1_valid  in   1      requester 1 (demo) has a command
// req1_cmd    in   CMD_W  requester 1 command
// req1_ready  out  1      requester 1 command accepted this cycle
// cmd_out     out  CMD_W  command held for the current frame
// cmd_strobe  out  1      1-cycle pulse when cmd_out is loaded from the FIFO
// fifo_count  out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
// - Clocking: one clock; reset is asynchronous and active-high.
// - Reset values: cmd_out=NOP_CMD, cmd_strobe=0, fifo_count=0,
//   req*_ready=0, FSM=IDLE, RR pointer=req0, vsync_q=1 (no false tick).
// - tick = vsync_q & ~vsync, i.e. the registered falling edge. Asserted in the
//   cycle of the edge; acted on at the next clk edge.
// - Handshake: transfer occurs when valid&ready in the same cycle.
//   req*_ready is combinational: grant & ~full. Grant: if only one port is
//   valid, that port wins. If both are valid, the RR pointer wins. The pointer
//   flips to the other port after each accepted transfer. Max one push/cycle.
// - NOP_CMD from a requester is accepted (ready=1) but not enqueued.
// - Full (count==DEPTH): both readys are 0. A same-cycle pop does not open
//   ready; ready is not looked at through the pop.
// - Push and pop in the same cycle: count is unchanged. Data ordering stays FIFO.
// - FSM, 2 states:
//   IDLE:   cmd_out=NOP_CMD. On tick, if count>0: pop into cmd_out,
//           cmd_strobe=1, go to ACTIVE. Otherwise stay in IDLE.
//   ACTIVE: hold cmd_out for the whole frame. On tick, if count>0: pop,
//           strobe, stay in ACTIVE. If empty: cmd_out=NOP_CMD, go to IDLE.
// - Latency: a command pushed into an empty FIFO appears on cmd_out 1 cycle
//   after the next tick. A push in the same cycle as the tick is not popped
//   on that tick.
// - Pointers wrap modulo DEPTH. Count never exceeds DEPTH or goes below 0.
// - Reset asserted mid-frame: FIFO is flushed and outputs return to reset
//   values at once, with no clock needed.
// CONFIGURATION
// - HOLD_LAST_EN defined: in ACTIVE, a tick with an empty FIFO keeps the last
//   cmd_out (no strobe) and the FSM stays in ACTIVE. The object keeps moving
//   until a NOP_CMD-free FIFO entry replaces the command, or reset.
// - HOLD_LAST_EN undefined: behaviour as described in BEHAVIOUR (revert to NOP).
// TESTING
// 1 Reset with vsync=1, then 3 ticks with no requests -> cmd_out=0,
//   cmd_strobe never 1, count=0.
// 2 req0 pushes 3'd2 then a tick -> strobe 1 cycle after the edge,
//   cmd_out=2 for the frame. At the next tick with empty FIFO -> cmd_out=0,
//   IDLE.
// 3 Both valid for 4 cycles, req0=1, req1=3, DEPTH=4 -> order 1,3,1,3.
//   Both readys 0 once count=4. Four ticks issue 1,3,1,3.
// 4 FIFO full, tick, and req1 valid in the same cycle -> req1_ready=0 that
//   cycle and 1 on the next cycle. Count goes 4->3->4.
// 5 req0 sends NOP_CMD -> req0_ready=1, count stays 0. Reset pulsed while
//   count=2 in ACTIVE -> count=0 and cmd_out=0 immediately.
// 6 With HOLD_LAST_EN: push 5, then 3 ticks -> cmd_out=5 for all 3 frames,
//   exactly one strobe.

Source files
------------

// File: rtl/frame_move_scheduler.sv
// Two-requester move-command FIFO that hands one command per video frame to the
// object-location block on the vsync falling edge. Optional macro: HOLD_LAST_EN.
module frame_move_scheduler #(
  parameter int               CMD_W   = 3,
  parameter int               DEPTH   = 4,
  parameter logic [CMD_W-1:0] NOP_CMD = '0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_vsync,
  input  logic                     i_req0_valid,
  input  logic [CMD_W-1:0]         i_req0_cmd,
  output logic                     o_req0_ready,
  input  logic                     i_req1_valid,
  input  logic [CMD_W-1:0]         i_req1_cmd,
  output logic                     o_req1_ready,
  output logic [CMD_W-1:0]         o_cmd_out,
  output logic                     o_cmd_strobe,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  typedef struct packed {
    logic             vld;
    logic [CMD_W-1:0] cmd;
  } req_t;

  state_t           r_state;
  logic             r_vsync_q;
  logic             r_rr;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [CMD_W-1:0] r_cmd_out;
  logic             r_strobe;

  req_t             w_req0, w_req1;
  logic             w_tick, w_full, w_gnt0, w_gnt1, w_rdy0, w_rdy1;
  logic             w_accept, w_push, w_pop;
  logic [CMD_W-1:0] w_acc_cmd;

  assign w_req0 = '{vld: i_req0_valid, cmd: i_req0_cmd};
  assign w_req1 = '{vld: i_req1_valid, cmd: i_req1_cmd};

  assign w_tick = r_vsync_q & ~i_vsync;
  assign w_full = (r_count == CW'(DEPTH));

  // Lone requester always wins; contention is settled by the round-robin bit.
  assign w_gnt0 = w_req0.vld & (~w_req1.vld | ~r_rr);
  assign w_gnt1 = w_req1.vld & (~w_req0.vld |  r_rr);
  assign w_rdy0 = w_gnt0 & ~w_full & ~i_reset;
  assign w_rdy1 = w_gnt1 & ~w_full & ~i_reset;

  assign w_accept  = w_rdy0 | w_rdy1;
  assign w_acc_cmd = w_rdy0 ? w_req0.cmd : w_req1.cmd;
  assign w_push    = w_accept & (w_acc_cmd != NOP_CMD);
  assign w_pop     = w_tick & (r_count != '0);

  assign o_req0_ready = w_rdy0;
  assign o_req1_ready = w_rdy1;
  assign o_cmd_out    = r_cmd_out;
  assign o_cmd_strobe = r_strobe;
  assign o_fifo_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= w_acc_cmd;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vsync_q <= 1'b1;
      r_rr      <= 1'b0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
    end else begin
      r_vsync_q <= i_vsync;
      if (w_accept) r_rr <= ~r_rr;
      if (w_push)   r_wr <= r_wr + AW'(1);
      if (w_pop)    r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cmd_out <= NOP_CMD;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_out <= NOP_CMD;
          if (w_pop) begin
            r_cmd_out <= r_mem[r_rd];
            r_strobe  <= 1'b1;
            r_state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_pop) begin
            r_cmd_out <= r_mem[r_rd];
            r_strobe  <= 1'b1;
          end else if (w_tick) begin
`ifdef HOLD_LAST_EN
            r_cmd_out <= r_cmd_out;
`else
            r_cmd_out <= NOP_CMD;
            r_state   <= IDLE;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_move_scheduler.sv
// Randomized and directed bench for frame_move_scheduler against a queue-based
// model of the command scheduling rules.
module tb_frame_move_scheduler;
  localparam int DEPTH = 4;
  localparam logic [2:0] NOP = 3'd0;

  logic       clk = 0, rst = 1, vs = 1;
  logic       v0 = 0, v1 = 0;
  logic [2:0] c0 = 0, c1 = 0;
  logic       r0, r1, strobe;
  logic [2:0] cmd;
  logic [2:0] cnt;

  frame_move_scheduler dut (
    .i_clk(clk), .i_reset(rst), .i_vsync(vs),
    .i_req0_valid(v0), .i_req0_cmd(c0), .o_req0_ready(r0),
    .i_req1_valid(v1), .i_req1_cmd(c1), .o_req1_ready(r1),
    .o_cmd_out(cmd), .o_cmd_strobe(strobe), .o_fifo_count(cnt));

  always #20 clk = ~clk;

  int checks = 0, errors = 0;
  logic [2:0] q[$];
  logic [2:0] issued[$];
  bit   m_rr, m_act, m_strobe, m_vq;
  logic [2:0] m_cmd;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); m_rr = 0; m_act = 0; m_strobe = 0; m_vq = 1; m_cmd = NOP;
  endtask

  // One clock: check outputs at negedge, advance model at posedge, return at posedge+1.
  task automatic cyc();
    bit tk, full, e0, e1;
    logic [2:0] ac, c;
    @(negedge clk);
    tk   = m_vq && !vs;
    full = (q.size() == DEPTH);
    e0   = v0 && (!v1 || !m_rr) && !full;
    e1   = v1 && (!v0 ||  m_rr) && !full;
    chk("rdy0", r0, e0);
    chk("rdy1", r1, e1);
    chk("cmd_out", cmd, m_cmd);
    chk("strobe", strobe, m_strobe);
    chk("count", cnt, q.size());
    if (strobe) issued.push_back(cmd);
    @(posedge clk);
    ac = e0 ? c0 : c1;
    m_strobe = 0;
    if (tk && q.size() > 0) begin
      c = q.pop_front();
      m_cmd = c; m_strobe = 1; m_act = 1;
    end else if (tk && m_act) begin
`ifndef HOLD_LAST_EN
      m_cmd = NOP; m_act = 0;
`endif
    end
    if (e0 || e1) begin
      m_rr = !m_rr;
      if (ac != NOP) q.push_back(ac);
    end
    m_vq = vs;
    #1;
  endtask

  task automatic do_reset();
    bit sv0, sv1;
    sv0 = v0; sv1 = v1;
    v0 = 1; v1 = 1;
    rst = 1;
    #1;
    chk("rst_count", cnt, 0);
    chk("rst_cmd", cmd, NOP);
    chk("rst_strobe", strobe, 0);
    chk("rst_rdy0", r0, 0);
    chk("rst_rdy1", r1, 0);
    model_reset();
    v0 = sv0; v1 = sv1; vs = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic frames(input int n, input int len);
    for (int f = 0; f < n; f++) begin
      vs = 0; cyc();
      vs = 1;
      for (int k = 0; k < len; k++) cyc();
    end
  endtask

  int exp3[4] = '{1, 3, 1, 3};
  int nstrobe;

  initial begin
    model_reset();
    #5; do_reset();

    // idle frames produce nothing
    frames(3, 5);
    chk("s1_no_strobe", issued.size(), 0);

    // single command, then revert on empty tick
    v0 = 1; c0 = 3'd2; cyc(); v0 = 0;
    frames(2, 5);
    chk("s2_issued", issued.size(), 1);
    if (issued.size() > 0) chk("s2_val", issued[0], 2);

    // contention alternates, fills to DEPTH
    do_reset(); issued.delete();
    v0 = 1; c0 = 3'd1; v1 = 1; c1 = 3'd3;
    for (int i = 0; i < 6; i++) cyc();
    v0 = 0; v1 = 0;
    frames(4, 4);
    chk("s3_n", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("s3_order", issued[i], exp3[i]);

    // full + tick + req1: no look-through on pop
    do_reset();
    v1 = 1; c1 = 3'd5;
    for (int i = 0; i < 4; i++) cyc();
    chk("s4_full", cnt, 4);
    c1 = 3'd6; vs = 0; cyc();
    vs = 1;
    chk("s4_cnt3", cnt, 3);
    chk("s4_rdy_open", r1, 1);
    cyc(); v1 = 0;
    chk("s4_cnt4", cnt, 4);
    frames(5, 3);

    // NOP accepted but dropped; reset mid-frame while ACTIVE
    do_reset();
    v0 = 1; c0 = NOP; cyc();
    chk("s5_nop_cnt", cnt, 0);
    c0 = 3'd2; cyc(); c0 = 3'd4; cyc(); c0 = 3'd7; cyc(); v0 = 0;
    vs = 0; cyc(); vs = 1; cyc(); cyc();
    chk("s5_cnt2", cnt, 2);
    @(posedge clk); #2;
    do_reset();

`ifdef HOLD_LAST_EN
    issued.delete();
    v0 = 1; c0 = 3'd5; cyc(); v0 = 0;
    frames(3, 4);
    chk("s6_strobes", issued.size(), 1);
    chk("s6_hold", cmd, 5);
`endif

    // randomized traffic with random frame lengths and occasional resets
    begin
      int flen, fpos;
      flen = 8; fpos = 0;
      for (int n = 0; n < 3000; n++) begin
        v0 = ($urandom_range(0, 3) != 0);
        v1 = ($urandom_range(0, 2) == 0);
        c0 = 3'($urandom_range(0, 7));
        c1 = 3'($urandom_range(0, 7));
        vs = (fpos >= 2);
        fpos++;
        if (fpos >= flen) begin fpos = 0; flen = $urandom_range(3, 14); end
        if ($urandom_range(0, 399) == 0) begin
          @(posedge clk); #($urandom_range(2, 30));
          do_reset();
          fpos = 2;
        end else begin
          cyc();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
